// File: rtl/riscv_core_pkg.sv
// rtl/riscv_core_pkg.sv - shared branch-predictor types and defaults
// Contents:
//   bp_cnt_e       2-bit saturating counter state (SNT/WNT/WT/ST)
//   BP_ENTRIES_DEF default number of predictor table entries
package riscv_core_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_e;

    localparam int BP_ENTRIES_DEF = 16;

endpackage

// File: rtl/riscv_core_bp_sat_counter.sv
// rtl/riscv_core_bp_sat_counter.sv - next state of a 2-bit saturating counter
// Ports:
//   i_cnt    current counter state
//   i_taken  resolved branch outcome
//   o_cnt    next counter state (saturates at SNT and ST)
module riscv_core_bp_sat_counter
    import riscv_core_pkg::*;
(
    input  bp_cnt_e i_cnt,
    input  logic    i_taken,
    output bp_cnt_e o_cnt
);

    always_comb begin
        o_cnt = i_cnt;
        unique case (i_cnt)
            SNT: o_cnt = i_taken ? WNT : SNT;
            WNT: o_cnt = i_taken ? WT  : SNT;
            WT:  o_cnt = i_taken ? ST  : WNT;
            ST:  o_cnt = i_taken ? ST  : WT;
            default: o_cnt = i_cnt;
        endcase
    end

endmodule

// File: rtl/riscv_core_branch_predictor.sv
// rtl/riscv_core_branch_predictor.sv - direct-mapped branch predictor with 2-bit counters
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_bp_fetch_pc            fetch PC looked up combinationally
//   o_bp_predict_taken       hit and counter predicts taken
//   o_bp_predict_target      stored target when predicting taken, else 0
//   i_bp_upd_*               resolved conditional branch update port
//   o_bp_mispredict          registered, one cycle after a wrong prediction
module riscv_core_branch_predictor
    import riscv_core_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int BP_ENTRIES = BP_ENTRIES_DEF,
    parameter int BP_IDX_W   = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_bp_fetch_pc,
    output logic            o_bp_predict_taken,
    output logic [XLEN-1:0] o_bp_predict_target,
    input  logic            i_bp_upd_valid,
    input  logic [XLEN-1:0] i_bp_upd_pc,
    input  logic            i_bp_upd_istaken,
    input  logic [XLEN-1:0] i_bp_upd_target,
    input  logic            i_bp_upd_predicted,
    output logic            o_bp_mispredict
);

    localparam int TAG_W = XLEN - BP_IDX_W - 1;

    logic            r_valid  [BP_ENTRIES];
    logic [TAG_W-1:0] r_tag   [BP_ENTRIES];
    logic [XLEN-1:0] r_target [BP_ENTRIES];
    bp_cnt_e         r_cnt    [BP_ENTRIES];
    logic            r_mispredict;

    // Bit 0 is always zero for halfword-aligned PCs and takes no part in indexing.
    logic                w_unused;
    logic [BP_IDX_W-1:0] w_fetch_idx;
    logic [TAG_W-1:0]    w_fetch_tag;
    logic                w_fetch_hit;
    logic [BP_IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0]    w_upd_tag;
    logic                w_upd_hit;
    bp_cnt_e             w_upd_cnt_next;

    assign w_unused    = i_bp_fetch_pc[0] ^ i_bp_upd_pc[0];
    assign w_fetch_idx = i_bp_fetch_pc[BP_IDX_W:1];
    assign w_fetch_tag = i_bp_fetch_pc[XLEN-1:BP_IDX_W+1];
    assign w_upd_idx   = i_bp_upd_pc[BP_IDX_W:1];
    assign w_upd_tag   = i_bp_upd_pc[XLEN-1:BP_IDX_W+1];

    // Asynchronous read: a same-cycle update is only visible after the edge.
    assign w_fetch_hit = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
    assign w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    assign o_bp_predict_taken  = w_fetch_hit && r_cnt[w_fetch_idx][1];
    assign o_bp_predict_target = o_bp_predict_taken ? r_target[w_fetch_idx] : '0;
    assign o_bp_mispredict     = r_mispredict;

    riscv_core_bp_sat_counter u_sat_counter (
        .i_cnt   (r_cnt[w_upd_idx]),
        .i_taken (i_bp_upd_istaken),
        .o_cnt   (w_upd_cnt_next)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BP_ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= WNT;
            end
            r_mispredict <= 1'b0;
        end else begin
            r_mispredict <= i_bp_upd_valid && (i_bp_upd_istaken != i_bp_upd_predicted);
            if (i_bp_upd_valid) begin
                if (w_upd_hit) begin
                    r_cnt[w_upd_idx] <= w_upd_cnt_next;
                    if (i_bp_upd_istaken) begin
                        r_target[w_upd_idx] <= i_bp_upd_target;
                    end
                end else if (i_bp_upd_istaken) begin
                    // Miss on a taken branch replaces whatever occupied the slot.
                    r_valid[w_upd_idx]  <= 1'b1;
                    r_tag[w_upd_idx]    <= w_upd_tag;
                    r_target[w_upd_idx] <= i_bp_upd_target;
                    r_cnt[w_upd_idx]    <= WT;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_core_branch_predictor.sv
// tb/tb_riscv_core_branch_predictor.sv - self-checking bench for riscv_core_branch_predictor
module tb_riscv_core_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] fetch_pc = '0;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [63:0] upd_pc = '0;
    logic        upd_istaken = 1'b0;
    logic [63:0] upd_target = '0;
    logic        upd_predicted = 1'b0;
    logic        mispredict;

    int checks = 0;
    int errors = 0;

    // Reference model: one slot per index, counter kept as an integer 0..3.
    bit              m_valid [16];
    longint unsigned m_tag   [16];
    longint unsigned m_tgt   [16];
    int              m_cnt   [16];

    riscv_core_branch_predictor #(
        .XLEN       (64),
        .BP_ENTRIES (16),
        .BP_IDX_W   (4)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_bp_fetch_pc       (fetch_pc),
        .o_bp_predict_taken  (pred_taken),
        .o_bp_predict_target (pred_target),
        .i_bp_upd_valid      (upd_valid),
        .i_bp_upd_pc         (upd_pc),
        .i_bp_upd_istaken    (upd_istaken),
        .i_bp_upd_target     (upd_target),
        .i_bp_upd_predicted  (upd_predicted),
        .o_bp_mispredict     (mispredict)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_idx(input longint unsigned pc);
        return int'((pc / 2) % 16);
    endfunction

    function automatic longint unsigned m_tagof(input longint unsigned pc);
        return pc / 32;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_cnt[i]   = 1;
        end
    endtask

    task automatic model_predict(input longint unsigned pc, output logic tk, output logic [63:0] tg);
        int i;
        i  = m_idx(pc);
        tk = m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_cnt[i] >= 2);
        tg = tk ? m_tgt[i] : 64'd0;
    endtask

    task automatic model_update(input longint unsigned pc, input logic tk, input longint unsigned tg);
        int i;
        i = m_idx(pc);
        if (m_valid[i] && m_tag[i] == m_tagof(pc)) begin
            if (tk) begin
                m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                m_tgt[i] = tg;
            end else begin
                m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
        end else if (tk) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = m_tagof(pc);
            m_tgt[i]   = tg;
            m_cnt[i]   = 2;
        end
    endtask

    // Called just after a rising edge: drive, check lookup (pre-update), clock, check mispredict.
    task automatic step(input logic [63:0] f_pc, input logic uv, input logic [63:0] u_pc,
                        input logic tk, input logic [63:0] tg, input logic pr);
        logic        e_tk;
        logic [63:0] e_tg;
        logic        e_mis;
        fetch_pc      = f_pc;
        upd_valid     = uv;
        upd_pc        = u_pc;
        upd_istaken   = tk;
        upd_target    = tg;
        upd_predicted = pr;
        #1;
        model_predict(f_pc, e_tk, e_tg);
        check("predict_taken", {63'd0, pred_taken}, {63'd0, e_tk});
        check("predict_target", pred_target, e_tg);
        e_mis = uv && (tk != pr);
        if (uv) model_update(u_pc, tk, tg);
        @(posedge clk);
        #1;
        check("mispredict", {63'd0, mispredict}, {63'd0, e_mis});
    endtask

    task automatic idle(input logic [63:0] f_pc);
        step(f_pc, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
    endtask

    initial begin
        logic [63:0] rpc;
        model_clear();

        // Outputs while reset is held.
        fetch_pc = 64'h8000_0000;
        #12;
        check("rst_taken", {63'd0, pred_taken}, 64'd0);
        check("rst_target", pred_target, 64'd0);
        check("rst_mispredict", {63'd0, mispredict}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        idle(64'h8000_0000);

        // First update after reset: taken miss allocates at WT, mispredicted.
        step(64'h8000_0010, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100, 1'b0);
        idle(64'h8000_0010);
        check("alloc_taken", {63'd0, pred_taken}, 64'd1);
        check("alloc_target", pred_target, 64'h8000_0100);
        check("mispredict_one_cycle", {63'd0, mispredict}, 64'd0);

        // Saturation up to ST, then down.
        repeat (3) step(64'h8000_0010, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100, 1'b1);
        step(64'h8000_0010, 1'b1, 64'h8000_0010, 1'b0, 64'h0, 1'b1);
        idle(64'h8000_0010);
        check("st_to_wt_taken", {63'd0, pred_taken}, 64'd1);
        step(64'h8000_0010, 1'b1, 64'h8000_0010, 1'b0, 64'h0, 1'b1);
        idle(64'h8000_0010);
        check("wt_to_wnt_taken", {63'd0, pred_taken}, 64'd0);

        // Re-strengthen, then alias with a different tag at index 8.
        step(64'h8000_0010, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100, 1'b0);
        step(64'h8000_0030, 1'b1, 64'h8000_0030, 1'b1, 64'h8000_0300, 1'b0);
        idle(64'h8000_0010);
        check("alias_old_miss", {63'd0, pred_taken}, 64'd0);
        idle(64'h8000_0030);
        check("alias_new_target", pred_target, 64'h8000_0300);

        // Same-cycle fetch and update on a fresh PC.
        step(64'h8000_0040, 1'b1, 64'h8000_0040, 1'b1, 64'h8000_0444, 1'b0);
        idle(64'h8000_0040);
        check("same_cycle_next", {63'd0, pred_taken}, 64'd1);

        // Randomized traffic over a small PC pool so hits, aliases and saturation all occur.
        for (int n = 0; n < 300; n++) begin
            rpc = 64'h8000_0000 + (64'($urandom_range(0, 47)) << 1);
            step(64'h8000_0000 + (64'($urandom_range(0, 47)) << 1),
                 1'($urandom_range(0, 3) != 0), rpc, 1'($urandom),
                 {32'h8000_0000, $urandom} & ~64'd1, 1'($urandom));
        end

        // Asynchronous reset mid-cycle during a mispredicted update; prior cycle also mispredicted.
        step(64'h8000_0040, 1'b1, 64'h8000_0040, 1'b1, 64'h8000_0444, 1'b0);
        fetch_pc      = 64'h8000_0040;
        upd_valid     = 1'b1;
        upd_pc        = 64'h8000_0050;
        upd_istaken   = 1'b1;
        upd_target    = 64'h8000_0555;
        upd_predicted = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_taken", {63'd0, pred_taken}, 64'd0);
        check("async_rst_target", pred_target, 64'd0);
        check("async_rst_mispredict", {63'd0, mispredict}, 64'd0);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        rst = 1'b0;
        model_clear();
        idle(64'h8000_0040);
        idle(64'h8000_0050);
        check("post_rst_empty", {63'd0, pred_taken}, 64'd0);

        // First update after reset release takes effect on the next edge.
        step(64'h8000_0050, 1'b1, 64'h8000_0050, 1'b1, 64'h8000_0777, 1'b1);
        idle(64'h8000_0050);
        check("post_rst_first_update", pred_target, 64'h8000_0777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
